reg_access_ctrl: RTL and testbench
==================================

Name: reg_access_ctrl

Overview:
- Initiator side of the register-file port: turns decode operand requests into get_reg_en fetch pulses, and ALU/flag results into reg_write_back pulses.
- Buffers write-backs in a small FIFO and drains them one per cycle.
- Forwards still-pending FIFO data onto fetched operands, so decode always sees program-order values.
- Sits between decode/execute and the register file.

Parameters:
- WORD, 16, data width (matches `WORD)
- DEPTH, 4, write-back FIFO entries (power of 2, >=2)
- SREG_IDX, 7, register index of the status register (matches `SREG)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  operand fetch request; accepted only when rd_ready=1
- rd_reg1  in  3  first operand register code
- rd_reg2  in  3  second operand register code
- rd_ready  out  1  high when state==IDLE
- rd_valid  out  1  one-cycle pulse: rd_data1/rd_data2/rd_sreg valid
- rd_data1  out  WORD  forwarded operand 1
- rd_data2  out  WORD  forwarded operand 2
- rd_sreg  out  WORD  forwarded status register
- wb_req  in  1  register write-back request
- wb_reg  in  3  write-back destination
- wb_data  in  WORD  write-back value
- flag_req  in  1  status-register update request
- flag_data  in  WORD  new SREG value
- wb_ready  out  1  (state==IDLE) && free slots >= 2
- drop_err  out  1  sticky: wb_req/flag_req seen while wb_ready=0
- get_reg_en  out  1  to register file: fetch strobe
- reg1  out  3  to register file
- reg2  out  3  to register file
- data_out1  in  WORD  from register file
- data_out2  in  WORD  from register file
- SREG_read  in  WORD  from register file
- reg_write_back  out  1  to register file: write strobe
- reg_write_code  out  3  to register file
- data_in  out  WORD  to register file

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; FIFO empty (pointers and count 0).
  - All outputs 0 except rd_ready=1 and wb_ready=1.
  - drop_err cleared. Pending writes are discarded, including mid-FETCH/CAPTURE.
- FSM:
  - IDLE: rd_req -> FETCH; latch rd_reg1/rd_reg2 into reg1/reg2.
  - FETCH: get_reg_en=1 for exactly this cycle. FIFO drain is stalled. Next state is always CAPTURE.
  - CAPTURE: sample data_out1/data_out2/SREG_read and apply forwarding. At the closing edge, register the results into rd_data*, set rd_valid=1 for the next cycle, and go to IDLE.
- Read latency: rd_req accepted in cycle 0 -> get_reg_en in cycle 1 -> rd_valid in cycle 3. Back-to-back fetch rate is 1 per 3 cycles. rd_req outside IDLE is ignored.
- Forwarding in CAPTURE:
  - For each operand, the youngest FIFO entry whose register code matches overrides the register-file value.
  - rd_sreg uses entries with reg==SREG_IDX.
  - Forwarding uses FIFO contents before any pop in that same cycle.
- Enqueue (only when wb_ready=1):
  - wb_req pushes {wb_reg, wb_data}.
  - flag_req pushes {SREG_IDX, flag_data}.
  - If both are asserted in the same cycle, push wb first, then flag (flag is the younger entry).
  - Writes accepted in the same cycle as an accepted rd_req are visible to that read via forwarding.
- Drain (combinational from FIFO head):
  - reg_write_back = !empty && state!=FETCH; reg_write_code/data_in = head entry; pop on that edge.
  - When empty, reg_write_code=0 and data_in=0.
- Simultaneous push and pop: count changes by (pushes - 1). Pointers wrap modulo DEPTH.
- Overflow protection: wb_ready requires 2 free slots, so the FIFO never overflows. Requests while wb_ready=0 are dropped and set drop_err.
- get_reg_en and reg_write_back are never both high in the same cycle.

Decomposition:
- Shared package/header (fmt.v): WORD, REGISTERS, SREG, and state encodings IDLE=2'd0, FETCH=2'd1, CAPTURE=2'd2.
- One sub-module, wb_fifo: DEPTH-entry FIFO with 2-push/1-pop ports, head output, and a parallel view of all entries with valid/age for forwarding.

Test Plan:
- Reset mid-FETCH with 3 queued writes -> get_reg_en=0, reg_write_back=0, wb_ready=1 the next cycle; no writes issued after release.
- Empty FIFO; rf R1=0x0011, R2=0x0022; rd_req(1,2) at cycle 0 -> get_reg_en only in cycle 1; rd_valid in cycle 3 with rd_data1=0x0011, rd_data2=0x0022.
- wb_req(R1,0xAAAA) then wb_req(R1,0xBBBB) in the same cycle as rd_req(1,3) -> rd_data1=0xBBBB (youngest wins). Register file receives 0xAAAA, then 0xBBBB, in order, with no write in cycle 1.
- wb_req(R4,0x1234) and flag_req(0x0003) in the same cycle -> two drain pulses: R4=0x1234, then R7=0x0003. A concurrent fetch returns rd_sreg=0x0003.
- Fill FIFO to 3 entries, then assert wb_req -> wb_ready=0, request dropped, drop_err=1 and stays 1 until reset.
- Drain a 4-entry FIFO while a fetch runs -> no pop in the FETCH cycle; total drain takes 5 cycles; wrap-around order preserved.

Source files
------------

// File: rtl/reg_access_ctrl_pkg.sv
// Shared constants for the register-file access controller: data width,
// register-code width, status-register index and FSM state encodings.
package reg_access_ctrl_pkg;

    localparam int WORD      = 16;
    localparam int REGISTERS = 8;
    localparam int REG_W     = $clog2(REGISTERS);
    localparam int SREG      = 7;

    typedef logic [REG_W-1:0] reg_code_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

endpackage

// File: rtl/reg_access_ctrl_wb_fifo.sv
// Write-back FIFO: up to two pushes and one pop per cycle, with an
// age-ordered view of every entry (index 0 = oldest) for operand forwarding.
module wb_fifo
    import reg_access_ctrl_pkg::*;
#(
    parameter int WORD  = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push0,
    input  logic [REG_W-1:0]       code0,
    input  logic [WORD-1:0]        data0,
    input  logic                   push1,
    input  logic [REG_W-1:0]       code1,
    input  logic [WORD-1:0]        data1,
    input  logic                   pop,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [REG_W-1:0]       head_code,
    output logic [WORD-1:0]        head_data,
    output logic [DEPTH-1:0]       ent_valid,
    output logic [REG_W-1:0]       ent_code [DEPTH],
    output logic [WORD-1:0]        ent_data [DEPTH]
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [1:0]       n_push;
    logic [REG_W-1:0] code_q [DEPTH];
    logic [WORD-1:0]  data_q [DEPTH];

    assign n_push    = {1'b0, push0} + {1'b0, push1};
    assign empty     = (count == '0);
    assign head_code = code_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    // push1 is only ever raised together with push0, so it lands one slot later
    always_ff @(posedge clk) begin
        if (push0) begin
            code_q[wr_ptr] <= code0;
            data_q[wr_ptr] <= data0;
        end
        if (push1) begin
            code_q[wr_ptr + PW'(1)] <= code1;
            data_q[wr_ptr + PW'(1)] <= data1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(n_push) - CW'(pop);
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ent_valid[k] = (CW'(k) < count);
            ent_code[k]  = code_q[rd_ptr + PW'(k)];
            ent_data[k]  = data_q[rd_ptr + PW'(k)];
        end
    end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register-file initiator: issues operand fetches with write-back forwarding
// and drains buffered write-backs one per cycle.
//
//   state   | meaning
//   IDLE    | accept rd_req and write-backs, drain FIFO
//   FETCH   | get_reg_en strobe to register file, drain stalled
//   CAPTURE | sample register file, forward pending writes, raise rd_valid
module reg_access_ctrl
    import reg_access_ctrl_pkg::*;
#(
    parameter int WORD     = 16,
    parameter int DEPTH    = 4,
    parameter int SREG_IDX = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [2:0]        rd_reg1,
    input  logic [2:0]        rd_reg2,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [WORD-1:0]   rd_data1,
    output logic [WORD-1:0]   rd_data2,
    output logic [WORD-1:0]   rd_sreg,
    input  logic              wb_req,
    input  logic [2:0]        wb_reg,
    input  logic [WORD-1:0]   wb_data,
    input  logic              flag_req,
    input  logic [WORD-1:0]   flag_data,
    output logic              wb_ready,
    output logic              drop_err,
    output logic              get_reg_en,
    output logic [2:0]        reg1,
    output logic [2:0]        reg2,
    input  logic [WORD-1:0]   data_out1,
    input  logic [WORD-1:0]   data_out2,
    input  logic [WORD-1:0]   SREG_read,
    output logic              reg_write_back,
    output logic [2:0]        reg_write_code,
    output logic [WORD-1:0]   data_in
);

    localparam int         CW        = $clog2(DEPTH) + 1;
    localparam logic [2:0] SREG_CODE = 3'(SREG_IDX);

    logic [1:0]       state;
    logic             wb_acc;
    logic             flag_acc;
    logic             push0;
    logic             push1;
    logic [2:0]       code0;
    logic [WORD-1:0]  data0;
    logic             pop;
    logic             empty;
    logic [CW-1:0]    count;
    logic [2:0]       head_code;
    logic [WORD-1:0]  head_data;
    logic [DEPTH-1:0] ent_valid;
    logic [2:0]       ent_code [DEPTH];
    logic [WORD-1:0]  ent_data [DEPTH];
    logic [WORD-1:0]  fwd1;
    logic [WORD-1:0]  fwd2;
    logic [WORD-1:0]  fwds;

    assign rd_ready   = (state == IDLE);
    assign wb_ready   = rd_ready && (count <= CW'(DEPTH - 2));
    assign get_reg_en = (state == FETCH);

    // wb occupies the older slot whenever both requests arrive together
    assign wb_acc   = wb_req && wb_ready;
    assign flag_acc = flag_req && wb_ready;
    assign push0    = wb_acc || flag_acc;
    assign push1    = wb_acc && flag_acc;
    assign code0    = wb_acc ? wb_reg : SREG_CODE;
    assign data0    = wb_acc ? wb_data : flag_data;

    assign pop            = !empty && (state != FETCH);
    assign reg_write_back = pop;
    assign reg_write_code = empty ? 3'd0 : head_code;
    assign data_in        = empty ? '0 : head_data;

    wb_fifo #(
        .WORD  (WORD),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push0     (push0),
        .code0     (code0),
        .data0     (data0),
        .push1     (push1),
        .code1     (SREG_CODE),
        .data1     (flag_data),
        .pop       (pop),
        .empty     (empty),
        .count     (count),
        .head_code (head_code),
        .head_data (head_data),
        .ent_valid (ent_valid),
        .ent_code  (ent_code),
        .ent_data  (ent_data)
    );

    // ascending age scan: the youngest matching entry is applied last and wins
    always_comb begin
        fwd1 = data_out1;
        fwd2 = data_out2;
        fwds = SREG_read;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_valid[k]) begin
                if (ent_code[k] == reg1)      fwd1 = ent_data[k];
                if (ent_code[k] == reg2)      fwd2 = ent_data[k];
                if (ent_code[k] == SREG_CODE) fwds = ent_data[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            reg1     <= '0;
            reg2     <= '0;
            rd_valid <= 1'b0;
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_sreg  <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        state <= FETCH;
                        reg1  <= rd_reg1;
                        reg2  <= rd_reg2;
                    end
                end
                FETCH: state <= CAPTURE;
                CAPTURE: begin
                    rd_data1 <= fwd1;
                    rd_data2 <= fwd2;
                    rd_sreg  <= fwds;
                    rd_valid <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else if ((wb_req || flag_req) && !wb_ready) begin
            drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: program-order register model with a per-cycle
// compare process, a behavioural register file, and directed scenarios.
module tb_reg_access_ctrl;

    localparam int WORD  = 16;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rd_req = 1'b0;
    logic [2:0]      rd_reg1 = '0;
    logic [2:0]      rd_reg2 = '0;
    logic            rd_ready;
    logic            rd_valid;
    logic [WORD-1:0] rd_data1;
    logic [WORD-1:0] rd_data2;
    logic [WORD-1:0] rd_sreg;
    logic            wb_req = 1'b0;
    logic [2:0]      wb_reg = '0;
    logic [WORD-1:0] wb_data = '0;
    logic            flag_req = 1'b0;
    logic [WORD-1:0] flag_data = '0;
    logic            wb_ready;
    logic            drop_err;
    logic            get_reg_en;
    logic [2:0]      reg1;
    logic [2:0]      reg2;
    logic [WORD-1:0] data_out1 = '0;
    logic [WORD-1:0] data_out2 = '0;
    logic [WORD-1:0] sreg_read = '0;
    logic            reg_write_back;
    logic [2:0]      reg_write_code;
    logic [WORD-1:0] data_in;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_access_ctrl #(.WORD(WORD), .DEPTH(DEPTH), .SREG_IDX(7)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rd_req         (rd_req),
        .rd_reg1        (rd_reg1),
        .rd_reg2        (rd_reg2),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data1       (rd_data1),
        .rd_data2       (rd_data2),
        .rd_sreg        (rd_sreg),
        .wb_req         (wb_req),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .flag_req       (flag_req),
        .flag_data      (flag_data),
        .wb_ready       (wb_ready),
        .drop_err       (drop_err),
        .get_reg_en     (get_reg_en),
        .reg1           (reg1),
        .reg2           (reg2),
        .data_out1      (data_out1),
        .data_out2      (data_out2),
        .SREG_read      (sreg_read),
        .reg_write_back (reg_write_back),
        .reg_write_code (reg_write_code),
        .data_in        (data_in)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Register file: writes on strobe, registered read one cycle after get_reg_en
    logic [WORD-1:0] rf [8] = '{16'h0000, 16'h0011, 16'h0022, 16'h0033,
                                16'h0044, 16'h0055, 16'h0066, 16'h0077};

    always @(posedge clk) begin
        if (reg_write_back) rf[reg_write_code] <= data_in;
        if (get_reg_en) begin
            data_out1 <= rf[reg1];
            data_out2 <= rf[reg2];
            sreg_read <= rf[7];
        end
    end

    // Program-order model: arch holds what decode must see, wq the writes the
    // register file has not yet received, in the order it must receive them.
    typedef struct {
        logic [2:0]      code;
        logic [WORD-1:0] data;
    } wr_t;

    wr_t             wq[$];
    logic [WORD-1:0] arch [8];
    int              phase = 0;
    bit              vpend = 0;
    bit              drop  = 0;
    logic [WORD-1:0] e1 = '0, e2 = '0, es = '0;
    logic [2:0]      l1 = '0, l2 = '0;

    always @(negedge clk) begin
        bit idle;
        bit wbr;
        bit drain;
        if (!rst_n) begin
            wq.delete();
            phase = 0;
            vpend = 0;
            drop  = 0;
            for (int i = 0; i < 8; i++) arch[i] = rf[i];
            check("rst_rd_ready", rd_ready, 1);
            check("rst_wb_ready", wb_ready, 1);
            check("rst_get_reg_en", get_reg_en, 0);
            check("rst_write_back", reg_write_back, 0);
            check("rst_rd_valid", rd_valid, 0);
            check("rst_drop_err", drop_err, 0);
            check("rst_write_code", reg_write_code, 0);
            check("rst_data_in", data_in, 0);
        end else begin
            idle  = (phase == 0);
            wbr   = idle && ((DEPTH - wq.size()) >= 2);
            drain = (wq.size() > 0) && (phase != 1);
            check("rd_ready", rd_ready, idle);
            check("wb_ready", wb_ready, wbr);
            check("get_reg_en", get_reg_en, phase == 1);
            if (phase == 1) begin
                check("reg1", reg1, l1);
                check("reg2", reg2, l2);
            end
            check("reg_write_back", reg_write_back, drain);
            if (drain) begin
                check("write_code", reg_write_code, wq[0].code);
                check("write_data", data_in, wq[0].data);
            end else if (wq.size() == 0) begin
                check("idle_write_code", reg_write_code, 0);
                check("idle_data_in", data_in, 0);
            end
            check("rd_valid", rd_valid, vpend);
            if (vpend) begin
                check("rd_data1", rd_data1, e1);
                check("rd_data2", rd_data2, e2);
                check("rd_sreg", rd_sreg, es);
            end
            check("drop_err", drop_err, drop);

            if (wbr) begin
                if (wb_req) begin
                    wq.push_back('{wb_reg, wb_data});
                    arch[wb_reg] = wb_data;
                end
                if (flag_req) begin
                    wq.push_back('{3'd7, flag_data});
                    arch[7] = flag_data;
                end
            end else if (wb_req || flag_req) begin
                drop = 1;
            end
            if (drain) void'(wq.pop_front());
            vpend = (phase == 2);
            case (phase)
                0: if (rd_req) begin
                    l1 = rd_reg1;
                    l2 = rd_reg2;
                    e1 = arch[rd_reg1];
                    e2 = arch[rd_reg2];
                    es = arch[7];
                    phase = 1;
                end
                1: phase = 2;
                default: phase = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rd_req = 0;
        wb_req = 0;
        flag_req = 0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] b);
        rd_req = 1;
        rd_reg1 = a;
        rd_reg2 = b;
    endtask

    task automatic wb(input logic [2:0] r, input logic [WORD-1:0] d);
        wb_req = 1;
        wb_reg = r;
        wb_data = d;
    endtask

    task automatic fl(input logic [WORD-1:0] d);
        flag_req = 1;
        flag_data = d;
    endtask

    typedef struct packed {
        logic            rd;
        logic [2:0]      r1;
        logic [2:0]      r2;
        logic            wb;
        logic [2:0]      wr;
        logic [WORD-1:0] wd;
        logic            fl;
        logic [WORD-1:0] fd;
    } vec_t;

    vec_t vecs [8] = '{
        '{1'b1, 3'd7, 3'd1, 1'b1, 3'd7, 16'h7007, 1'b0, 16'h0000},
        '{1'b1, 3'd2, 3'd2, 1'b1, 3'd2, 16'h2020, 1'b1, 16'h0F0F},
        '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0F0E},
        '{1'b1, 3'd0, 3'd7, 1'b1, 3'd0, 16'h0BAD, 1'b0, 16'h0000},
        '{1'b0, 3'd0, 3'd0, 1'b1, 3'd4, 16'h4444, 1'b1, 16'h1234},
        '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000},
        '{1'b1, 3'd4, 3'd0, 1'b1, 3'd4, 16'h4545, 1'b1, 16'h5678},
        '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000}
    };

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        rst_n = 0;
        repeat (3) tick();
        rst_n = 1;
        tick();
        tick();

        // plain fetch, empty FIFO
        rd(1, 2);
        tick(); clr();
        check("t1_get_en_c1", get_reg_en, 1);
        tick();
        check("t1_get_en_c2", get_reg_en, 0);
        tick();
        check("t1_valid_c3", rd_valid, 1);
        check("t1_d1", rd_data1, 16'h0011);
        check("t1_d2", rd_data2, 16'h0022);
        tick();

        // youngest same-register write wins
        wb(1, 16'hAAAA);
        tick(); clr();
        wb(1, 16'hBBBB); rd(1, 3);
        check("t2_wb_c0", reg_write_back, 1);
        check("t2_data_c0", data_in, 16'hAAAA);
        tick(); clr();
        check("t2_wb_c1", reg_write_back, 0);
        tick();
        check("t2_wb_c2", reg_write_back, 1);
        check("t2_data_c2", data_in, 16'hBBBB);
        tick();
        check("t2_d1", rd_data1, 16'hBBBB);
        check("t2_d2", rd_data2, 16'h0033);
        tick();

        // wb and flag in one cycle with a concurrent fetch
        wb(4, 16'h1234); fl(16'h0003); rd(4, 5);
        tick(); clr();
        tick();
        check("t3_code_c2", reg_write_code, 4);
        check("t3_data_c2", data_in, 16'h1234);
        tick();
        check("t3_code_c3", reg_write_code, 7);
        check("t3_data_c3", data_in, 16'h0003);
        check("t3_d1", rd_data1, 16'h1234);
        check("t3_d2", rd_data2, 16'h0055);
        check("t3_sreg", rd_sreg, 16'h0003);
        tick();
        check("t3_wb_c4", reg_write_back, 0);

        // overflow protection and sticky drop_err
        wb(2, 16'h2222); fl(16'h0700);
        tick(); clr();
        check("t4_wb_ready_2", wb_ready, 1);
        wb(3, 16'h3333); fl(16'h0701);
        tick(); clr();
        check("t4_wb_ready_3", wb_ready, 0);
        check("t4_drop_before", drop_err, 0);
        wb(5, 16'h5555);
        tick(); clr();
        check("t4_drop_set", drop_err, 1);
        repeat (4) tick();
        check("t4_drop_sticky", drop_err, 1);
        rd(5, 3);
        tick(); clr();
        tick(); tick();
        check("t4_d1_not_written", rd_data1, 16'h0055);
        check("t4_d2", rd_data2, 16'h3333);
        tick();

        // four writes drained around a fetch stall
        wb(6, 16'h6666); fl(16'h0600);
        tick(); clr();
        wb(1, 16'h1111); fl(16'h0601); rd(6, 7);
        check("t5_data_c1", data_in, 16'h6666);
        tick(); clr();
        check("t5_stall_c2", reg_write_back, 0);
        tick();
        check("t5_data_c3", data_in, 16'h0600);
        tick();
        check("t5_data_c4", data_in, 16'h1111);
        check("t5_d1", rd_data1, 16'h6666);
        check("t5_sreg", rd_sreg, 16'h0601);
        tick();
        check("t5_data_c5", data_in, 16'h0601);
        tick();
        check("t5_done_c6", reg_write_back, 0);
        check("t5_drop_still", drop_err, 1);

        // reset during FETCH with three writes queued
        wb(2, 16'hA2A2); fl(16'h0A00);
        tick(); clr();
        wb(3, 16'hA3A3); fl(16'h0A01); rd(2, 3);
        tick(); clr();
        check("t6_in_fetch", get_reg_en, 1);
        rst_n = 0;
        #1;
        check("t6_rst_get_en", get_reg_en, 0);
        check("t6_rst_wb", reg_write_back, 0);
        check("t6_rst_wb_ready", wb_ready, 1);
        check("t6_rst_drop", drop_err, 0);
        tick(); tick();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_no_write", reg_write_back, 0);
        end
        rd(2, 3);
        tick(); clr();
        tick(); tick();
        check("t6_d1", rd_data1, 16'hA2A2);
        check("t6_d2", rd_data2, 16'h3333);
        tick();

        // mixed vectors, including requests outside IDLE
        for (int i = 0; i < 8; i++) begin
            rd_req = vecs[i].rd;
            rd_reg1 = vecs[i].r1;
            rd_reg2 = vecs[i].r2;
            wb_req = vecs[i].wb;
            wb_reg = vecs[i].wr;
            wb_data = vecs[i].wd;
            flag_req = vecs[i].fl;
            flag_data = vecs[i].fd;
            tick();
        end
        clr();
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
